// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display geometry, scanout state encoding and
// the byte-select helper used to serialise the framebuffer.
package chip8_pkg;

    localparam int DISP_W     = 64;
    localparam int DISP_H     = 32;
    localparam int DISP_BITS  = DISP_W * DISP_H;
    localparam int SCAN_BYTES = DISP_BITS / 8;

    typedef enum logic {
        IDLE,
        SEND
    } scan_state_t;

    // Eight pixels starting at bit 8*k; the leftmost pixel lands in bit 7.
    function automatic logic [7:0] scan_byte(
        input logic [DISP_BITS-1:0] fb,
        input logic [7:0]           k
    );
        logic [7:0] raw;
        logic [7:0] b;
        raw = fb[{k, 3'b000} +: 8];
        for (int i = 0; i < 8; i++) begin
            b[7-i] = raw[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/chip8_frame_divider.sv
// Free-running modulo-FRAME_DIV counter emitting a one-cycle tick
// in the last count of each period.
module chip8_frame_divider #(
    parameter int FRAME_DIV = 16666
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = $clog2(FRAME_DIV);
    localparam logic [W-1:0] LAST = W'(FRAME_DIV - 1);

    logic [W-1:0] div;

    assign tick = (div == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/chip8_frame_scanout.sv
// Snapshots the CHIP-8 framebuffer on each frame tick and streams
// it as 256 packed bytes over a valid/ready link.
module chip8_frame_scanout
    import chip8_pkg::*;
#(
    parameter int FRAME_DIV = 16666,
    parameter bit SKIP_SAME = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DISP_BITS-1:0] display,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [7:0]           pix_data,
    output logic                 pix_sof,
    output logic                 pix_eol,
    output logic                 frame_tick,
    output logic [15:0]          frame_count,
    output logic                 overrun
);

    localparam logic [7:0] LAST_K = 8'(SCAN_BYTES - 1);

    logic                 tick;
    scan_state_t          state, state_n;
    logic [7:0]           k, k_n;
    logic [DISP_BITS-1:0] snap, snap_n;
    logic [DISP_BITS-1:0] last, last_n;
    logic [15:0]          count_n;
    logic                 overrun_n;
    logic                 valid_n;
    logic [7:0]           data_n;
    logic                 sof_n;
    logic                 eol_n;

    chip8_frame_divider #(
        .FRAME_DIV(FRAME_DIV)
    ) u_div (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign frame_tick = tick;

    always_comb begin
        state_n   = state;
        k_n       = k;
        snap_n    = snap;
        last_n    = last;
        count_n   = frame_count;
        overrun_n = overrun;
        valid_n   = pix_valid;
        unique case (state)
            IDLE: begin
                valid_n = 1'b0;
                if (tick) begin
                    snap_n = display;
                    if (!(SKIP_SAME && (display == last))) begin
                        k_n     = '0;
                        valid_n = 1'b1;
                        state_n = SEND;
                    end
                end
            end
            SEND: begin
                // A tick here is dropped; the frame in flight is untouched.
                if (tick) begin
                    overrun_n = 1'b1;
                end
                if (pix_valid && pix_ready) begin
                    if (k == LAST_K) begin
                        last_n  = snap;
                        count_n = frame_count + 16'd1;
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end else begin
                        k_n = k + 8'd1;
                    end
                end
            end
        endcase
        data_n = valid_n ? scan_byte(snap_n, k_n) : 8'h00;
        sof_n  = valid_n && (k_n == 8'd0);
        eol_n  = valid_n && (k_n[2:0] == 3'd7);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            k           <= '0;
            snap        <= '0;
            last        <= '0;
            frame_count <= '0;
            overrun     <= 1'b0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
        end else begin
            state       <= state_n;
            k           <= k_n;
            snap        <= snap_n;
            last        <= last_n;
            frame_count <= count_n;
            overrun     <= overrun_n;
            pix_valid   <= valid_n;
            pix_data    <= data_n;
            pix_sof     <= sof_n;
            pix_eol     <= eol_n;
        end
    end

endmodule

// File: doc/chip8_frame_scanout.md
# chip8_frame_scanout

Frame scanout stage directly downstream of `chip8_top`. It consumes the 2048-bit `display` framebuffer and generates a 60 Hz frame tick from the system clock. On each tick it snapshots the framebuffer and streams it out as 256 packed bytes over a valid/ready interface toward the panel/host driver. Optionally it suppresses frames identical to the last one sent.

## Interface
Parameters:
- `FRAME_DIV`, 16666: clk cycles per frame tick. Must be ≥ 2.
- `SKIP_SAME`, 0: 1 = do not stream a snapshot equal to the last streamed frame.

Ports:
- `clk` in 1: single system clock; all logic on posedge.
- `reset` in 1: asynchronous, active-low; assertion clears all state immediately.
- `display` in 2048: framebuffer. Pixel (x,y) = `display[y*64+x]`, x 0..63, y 0..31.
- `pix_valid` out 1: byte on `pix_data` is valid.
- `pix_ready` in 1: sink accepts the byte when `pix_valid && pix_ready`.
- `pix_data` out 8: eight horizontally adjacent pixels; bit7 = leftmost.
- `pix_sof` out 1: qualifies byte 0 of a frame.
- `pix_eol` out 1: qualifies the last byte of each row (byte index % 8 == 7).
- `frame_tick` out 1: one-cycle pulse each `FRAME_DIV` cycles.
- `frame_count` out 16: completed streamed frames; wraps 0xFFFF→0.
- `overrun` out 1: sticky; set when a tick arrives while still streaming. Cleared only by reset.

## Operation
- Divider `div` counts 0..FRAME_DIV-1 and wraps. `frame_tick`=1 in the cycle `div`==FRAME_DIV-1.
- Two-state FSM, IDLE / SEND.
- IDLE, tick present: latch `display` into `snap`.
  - If SKIP_SAME=1 and `snap`==`last`, remain IDLE.
  - Otherwise set byte index `k`=0 and go to SEND.
- SEND: present byte k.
  - `pix_data` = `snap[y*64+8c+7 .. y*64+8c]`, bit-reversed so pixel x=8c is bit7. Here y=k/8, c=k%8.
  - On handshake: if k==255, copy `snap` to `last`, increment `frame_count`, go to IDLE. Otherwise k++.
- Tick during SEND: tick ignored (no re-snapshot, stream unaffected); `overrun` set.
- Outputs are registered. `pix_data`, `pix_sof` and `pix_eol` stay stable while `pix_valid && !pix_ready`.
- Tick and the final handshake in the same cycle: final handshake completes (→IDLE); tick counts as overrun and is dropped.
- `display` changes during SEND do not affect the frame in flight.
- Reset mid-frame: stream aborts; no partial-frame completion; `last` cleared to 0.

## Timing
- Reset values: `pix_valid`=0, `pix_data`=0, `pix_sof`=0, `pix_eol`=0, `frame_tick`=0, `frame_count`=0, `overrun`=0. Also `div`=0, `k`=0, `snap`=0, `last`=0, state IDLE.
- First `frame_tick` occurs FRAME_DIV cycles after reset deasserts, i.e. in the cycle `div` reaches FRAME_DIV-1.
- Tick at cycle T → `pix_valid`=1 with byte 0 and `pix_sof`=1 at T+1.
- With `pix_ready` held high: one byte per cycle; final byte at T+256; `pix_valid`=0 and `frame_count` updated at T+257.
- No overrun is possible when FRAME_DIV ≥ 257 and ready is held high.
- SKIP_SAME suppressed frame: `pix_valid` never rises; `frame_count` unchanged.

## Structure
- `chip8_pkg` holds:
  - `DISP_W`=64, `DISP_H`=32, `DISP_BITS`=2048, `SCAN_BYTES`=256.
  - The state enum {IDLE, SEND}.
  - These are shared with `chip8_top` display logic.
- Sub-module `chip8_frame_divider` (params FRAME_DIV; ports clk, reset, tick) contains the divider. Reused for the CPU delay/sound timers.
- Byte select is combinational from `snap` and `k`, registered into `pix_data`.

## Test plan
- FRAME_DIV=300, `pix_ready`=1, display all 1s:
  - first tick 300 cycles after reset release;
  - 256 bytes of 0xFF;
  - `pix_sof` only on byte 0;
  - `pix_eol` on bytes 7, 15, …, 255;
  - `frame_count`=1 at tick+257.
- Only pixel (0,0) set → byte 0 = 0x80, all others 0x00. Then only pixel (63,31) set → byte 255 = 0x01.
- `pix_ready` toggled 1-in-3, with `display` changed mid-stream:
  - data/sof/eol held stable while stalled;
  - streamed frame equals the snapshot taken at the tick;
  - `overrun` stays 0 for FRAME_DIV=1000.
- FRAME_DIV=100, ready=1: tick arrives during SEND → `overrun`=1 and stays 1; current frame completes intact.
- SKIP_SAME=1, static display: first frame streamed; next ticks produce no `pix_valid`; `frame_count` stays 1. Flipping one pixel → next tick streams a frame; count = 2.
- Reset (low) asserted at byte 100:
  - outputs return to reset values asynchronously;
  - after release, `frame_count`=0;
  - next frame starts at byte 0 with `pix_sof`=1.
